// File: rtl/aes_pkg.sv
// Shared AES constants, GF(2^8) helpers and FSM encoding for the inverse cipher.
package aes_pkg;

   localparam int AES128_ROUNDS = 10;
   // rcon value left behind once the forward schedule has produced rk10
   localparam logic [7:0] RCON_RK10 = 8'h6c;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_EXPAND = 3'd1,
      ST_LOAD   = 3'd2,
      ST_ROUND  = 3'd3,
      ST_FINAL  = 3'd4,
      ST_DONE   = 3'd5
   } aes_inv_state_e;

   localparam logic [7:0] RCON [AES128_ROUNDS] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16};

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d};

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
   endfunction

   // exact inverse of xtime, used to walk rcon back down the schedule
   function automatic logic [7:0] inv_xtime(input logic [7:0] b);
      return {1'b0, b[7:1]} ^ (8'h8d & {8{b[0]}});
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         p  = p ^ (aa & {8{b[i]}});
         aa = xtime(aa);
      end
      return p;
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction

endpackage

// File: rtl/aes_inv_round_comb.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the last round.
module aes_inv_round_comb
   import aes_pkg::*;
(
   input  logic [127:0] st,
   input  logic [127:0] rk,
   input  logic         last,
   output logic [127:0] nxt
);

   logic [7:0] ark_s [16];
   logic [7:0] mix_s [16];

   // byte index = 4*column + row; row r is rotated right by r columns
   always_comb begin
      nxt = 128'h0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            ark_s[4*c+r] = INV_SBOX[st[127 - 8*(4*((c - r + 4) % 4) + r) -: 8]]
                         ^ rk[127 - 8*(4*c + r) -: 8];
         end
      end
      for (int c = 0; c < 4; c++) begin
         mix_s[4*c+0] = gmul(ark_s[4*c], 8'h0e) ^ gmul(ark_s[4*c+1], 8'h0b)
                      ^ gmul(ark_s[4*c+2], 8'h0d) ^ gmul(ark_s[4*c+3], 8'h09);
         mix_s[4*c+1] = gmul(ark_s[4*c], 8'h09) ^ gmul(ark_s[4*c+1], 8'h0e)
                      ^ gmul(ark_s[4*c+2], 8'h0b) ^ gmul(ark_s[4*c+3], 8'h0d);
         mix_s[4*c+2] = gmul(ark_s[4*c], 8'h0d) ^ gmul(ark_s[4*c+1], 8'h09)
                      ^ gmul(ark_s[4*c+2], 8'h0e) ^ gmul(ark_s[4*c+3], 8'h0b);
         mix_s[4*c+3] = gmul(ark_s[4*c], 8'h0b) ^ gmul(ark_s[4*c+1], 8'h0d)
                      ^ gmul(ark_s[4*c+2], 8'h09) ^ gmul(ark_s[4*c+3], 8'h0e);
      end
      for (int i = 0; i < 16; i++) begin
         nxt[127 - 8*i -: 8] = last ? ark_s[i] : mix_s[i];
      end
   end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher, one round per clock, round keys generated on the fly.
// Optional AES_INV_KEY_CACHE_EN keeps the last key and its rk10 to skip key expansion.
module aes_inv_cipher_iter
   import aes_pkg::*;
#(
   parameter int ROUNDS = AES128_ROUNDS
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] ct,
   input  logic [127:0] key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] pt,
   output logic         busy
);

   if (ROUNDS != AES128_ROUNDS) begin : g_rounds_check
      $error("aes_inv_cipher_iter supports only ROUNDS = 10");
   end

   localparam logic [3:0] LAST_STEP = 4'(ROUNDS - 1);

   aes_inv_state_e state_r;
   aes_inv_state_e state_s;

   logic [127:0] ct_r;
   logic [127:0] st_r;
   logic [127:0] krk_r;
   logic [7:0]   rcon_r;
   logic [3:0]   cnt_r;
   logic [127:0] pt_r;
   logic         out_valid_r;

   logic         xfer_s;
   logic         cache_hit_s;
   logic [127:0] cache_rk10_s;
   logic [127:0] krk_fwd_s;
   logic [127:0] kprev_s;
   logic [7:0]   rcon_prev_s;
   logic [127:0] round_out_s;
   logic [31:0]  fw0_s, fw1_s, fw2_s, fw3_s;
   logic [31:0]  bw0_s, bw1_s, bw2_s, bw3_s;

   assign xfer_s = in_valid && (state_r == ST_IDLE);

   // forward and backward key-schedule steps on the current round key
   always_comb begin
      fw0_s       = krk_r[127:96] ^ sub_word(rot_word(krk_r[31:0])) ^ {rcon_r, 24'h000000};
      fw1_s       = krk_r[95:64] ^ fw0_s;
      fw2_s       = krk_r[63:32] ^ fw1_s;
      fw3_s       = krk_r[31:0]  ^ fw2_s;
      krk_fwd_s   = {fw0_s, fw1_s, fw2_s, fw3_s};
      rcon_prev_s = inv_xtime(rcon_r);
      bw3_s       = krk_r[31:0]  ^ krk_r[63:32];
      bw2_s       = krk_r[63:32] ^ krk_r[95:64];
      bw1_s       = krk_r[95:64] ^ krk_r[127:96];
      bw0_s       = krk_r[127:96] ^ sub_word(rot_word(bw3_s)) ^ {rcon_prev_s, 24'h000000};
      kprev_s     = {bw0_s, bw1_s, bw2_s, bw3_s};
   end

   aes_inv_round_comb u_round (
      .st   (st_r),
      .rk   (kprev_s),
      .last (state_r == ST_FINAL),
      .nxt  (round_out_s)
   );

`ifdef AES_INV_KEY_CACHE_EN
   logic [127:0] key_r;
   logic [127:0] cache_key_r;
   logic [127:0] cache_rk10_r;
   logic         cache_vld_r;

   assign cache_hit_s  = cache_vld_r && (key == cache_key_r);
   assign cache_rk10_s = cache_rk10_r;

   // captures the key on transfer and refreshes the cache when expansion completes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_r        <= 128'h0;
         cache_key_r  <= 128'h0;
         cache_rk10_r <= 128'h0;
         cache_vld_r  <= 1'b0;
      end else begin
         if (xfer_s) begin
            key_r <= key;
         end
         if ((state_r == ST_EXPAND) && (cnt_r == LAST_STEP)) begin
            cache_key_r  <= key_r;
            cache_rk10_r <= krk_fwd_s;
            cache_vld_r  <= 1'b1;
         end
      end
   end
`else
   assign cache_hit_s  = 1'b0;
   assign cache_rk10_s = 128'h0;
`endif

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // next-state decode
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE:   state_s = xfer_s ? (cache_hit_s ? ST_LOAD : ST_EXPAND) : ST_IDLE;
         ST_EXPAND: state_s = (cnt_r == LAST_STEP) ? ST_LOAD : ST_EXPAND;
         ST_LOAD:   state_s = ST_ROUND;
         ST_ROUND:  state_s = (cnt_r == 4'd1) ? ST_FINAL : ST_ROUND;
         ST_FINAL:  state_s = ST_DONE;
         ST_DONE:   state_s = out_ready ? ST_IDLE : ST_DONE;
         default:   state_s = ST_IDLE;
      endcase
   end

   // handshake status decoded from state only
   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b1;
      case (state_r)
         ST_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
         end
         default: begin
            in_ready = 1'b0;
            busy     = 1'b1;
         end
      endcase
   end

   // round datapath, key walk and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ct_r        <= 128'h0;
         st_r        <= 128'h0;
         krk_r       <= 128'h0;
         rcon_r      <= 8'h00;
         cnt_r       <= 4'd0;
         pt_r        <= 128'h0;
         out_valid_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (xfer_s) begin
                  ct_r   <= ct;
                  krk_r  <= cache_hit_s ? cache_rk10_s : key;
                  rcon_r <= cache_hit_s ? RCON_RK10 : RCON[0];
                  cnt_r  <= 4'd0;
               end
            end
            ST_EXPAND: begin
               krk_r  <= krk_fwd_s;
               rcon_r <= xtime(rcon_r);
               cnt_r  <= cnt_r + 4'd1;
            end
            ST_LOAD: begin
               st_r  <= ct_r ^ krk_r;
               cnt_r <= LAST_STEP;
            end
            ST_ROUND: begin
               st_r   <= round_out_s;
               krk_r  <= kprev_s;
               rcon_r <= rcon_prev_s;
               cnt_r  <= cnt_r - 4'd1;
            end
            ST_FINAL: begin
               pt_r        <= round_out_s;
               out_valid_r <= 1'b1;
               krk_r       <= kprev_s;
               rcon_r      <= rcon_prev_s;
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
               end
            end
            default: begin
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign pt        = pt_r;
   assign out_valid = out_valid_r;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Scoreboard bench for aes_inv_cipher_iter using FIPS-197 vectors; latency
// expectations follow AES_INV_KEY_CACHE_EN when it is defined.
module tb_aes_inv_cipher_iter;

   localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_PT   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT    = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_PT    = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam int MISS_LAT = 21;
`ifdef AES_INV_KEY_CACHE_EN
   localparam int HIT_LAT = 11;
`else
   localparam int HIT_LAT = 21;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] ct;
   logic [127:0] key;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] pt;
   logic         busy;

   aes_inv_cipher_iter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ct        (ct),
      .key       (key),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .pt        (pt),
      .busy      (busy)
   );

   typedef struct {
      logic [127:0] pt;
      int           lat;
      int           xcyc;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   logic ov_prev = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: actual %h required %h", name, act, req);
      end
   endtask

   // monitor: compare every rising out_valid against the oldest expectation
   always @(negedge clk) begin : monitor
      exp_t e;
      if (out_valid && !ov_prev) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_output: actual pt %h required no output", pt);
         end else begin
            e = exp_q.pop_front();
            chk("pt", pt, e.pt);
            chk("latency", 128'(cyc - e.xcyc), 128'(e.lat));
         end
      end
      ov_prev <= out_valid;
   end

   task automatic send(input logic [127:0] c, input logic [127:0] k,
                       input logic [127:0] p, input int lat, input bit track);
      int w;
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("in_ready_wait", 128'(in_ready), 128'(1'b1));
      ct       = c;
      key      = k;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      if (track) exp_q.push_back('{pt: p, lat: lat, xcyc: cyc});
      in_valid = 1'b0;
      ct       = 128'hdeadbeef_cafef00d_01234567_89abcdef;
      key      = 128'h0;
   endtask

   task automatic wait_done(input string name);
      int w;
      w = 0;
      while ((exp_q.size() != 0 || !in_ready) && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk(name, 128'(in_ready && (exp_q.size() == 0)), 128'(1'b1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      ct        = 128'h0;
      key       = 128'h0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 128'(in_ready), 128'(1'b1));
      chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
      chk("rst_busy", 128'(busy), 128'(1'b0));
      chk("rst_pt", pt, 128'h0);
      rst_n = 1'b1;

      // C.1 cold, then the same key again (cache hit when enabled)
      send(C1_CT, C1_KEY, C1_PT, MISS_LAT, 1'b1);
      chk("busy_running", 128'(busy), 128'(1'b1));
      chk("in_ready_running", 128'(in_ready), 128'(1'b0));
      wait_done("c1_done");
      send(C1_CT, C1_KEY, C1_PT, HIT_LAT, 1'b1);
      wait_done("c1_again_done");

      // App. B with internal rk10 check after expansion
      send(B_CT, B_KEY, B_PT, MISS_LAT, 1'b1);
      repeat (10) @(posedge clk);
      #1;
      chk("rk10", dut.krk_r, B_RK10);
      wait_done("appb_done");

      // backpressure
      out_ready = 1'b0;
      send(B_CT, B_KEY, B_PT, HIT_LAT, 1'b1);
      for (int w = 0; w < 40 && !out_valid; w++) @(negedge clk);
      chk("bp_out_valid_rise", 128'(out_valid), 128'(1'b1));
      repeat (15) begin
         @(negedge clk);
         chk("bp_pt_hold", pt, B_PT);
         chk("bp_out_valid_hold", 128'(out_valid), 128'(1'b1));
         chk("bp_in_ready_low", 128'(in_ready), 128'(1'b0));
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_release_in_ready", 128'(in_ready), 128'(1'b1));
      chk("bp_release_out_valid", 128'(out_valid), 128'(1'b0));
      wait_done("bp_done");

      // reset in the middle of ROUND
      send(C1_CT, C1_KEY, C1_PT, MISS_LAT, 1'b0);
      repeat (15) @(negedge clk);
      chk("busy_before_reset", 128'(busy), 128'(1'b1));
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 128'(out_valid), 128'(1'b0));
      chk("mid_rst_in_ready", 128'(in_ready), 128'(1'b1));
      chk("mid_rst_busy", 128'(busy), 128'(1'b0));
      chk("mid_rst_pt", pt, 128'h0);
      @(negedge clk);
      rst_n = 1'b1;
      send(C1_CT, C1_KEY, C1_PT, MISS_LAT, 1'b1);
      wait_done("post_reset_done");

      // in_valid held high with changing inputs while busy
      @(negedge clk);
      ct       = C1_CT;
      key      = C1_KEY;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      exp_q.push_back('{pt: C1_PT, lat: HIT_LAT, xcyc: cyc});
      for (int w = 0; w < 40; w++) begin
         @(negedge clk);
         if (out_valid) break;
         ct  = {$urandom(), $urandom(), $urandom(), $urandom()};
         key = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      in_valid = 1'b0;
      wait_done("hold_valid_done");
      repeat (25) @(negedge clk);
      chk("no_extra_output", 128'(exp_q.size()), 128'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
